// File: rtl/tcdm_master_shim.sv
// Per-master TCDM front end: request FIFO, bank/row decode, outstanding cap, registered responses.
// Optional XOR bank scrambling enabled by defining TCDM_SHIM_SCRAMBLE_EN.
module tcdm_master_shim #(
    parameter int unsigned NumBanks  = 16,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned MaxOutst  = 8,
    localparam int unsigned BankBits = $clog2(NumBanks),
    localparam int unsigned BeWidth  = DataWidth / 8,
    localparam int unsigned OffBits  = $clog2(BeWidth),
    localparam int unsigned RowWidth = AddrWidth - OffBits - BankBits,
    localparam int unsigned OutstW   = $clog2(MaxOutst + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [AddrWidth-1:0] add_i,
    input  logic                 wen_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 req_o,
    output logic [BankBits-1:0]  bank_o,
    output logic [RowWidth-1:0]  add_o,
    output logic                 wen_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic [BeWidth-1:0]   be_o,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic [OutstW-1:0]    outst_o,
    output logic                 err_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic [BankBits-1:0]  bank;
        logic [RowWidth-1:0]  row;
        logic                 wen;
        logic [DataWidth-1:0] wdata;
        logic [BeWidth-1:0]   be;
    } entry_t;

    entry_t               mem_q [FifoDepth];
    entry_t               mem_d [FifoDepth];
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [OutstW-1:0]    popped_q, popped_d;
    logic                 rvalid_q, rvalid_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 fifo_full, fifo_empty, push, pop;
    logic [OutstW-1:0]    outst;
    logic [BankBits-1:0]  bank_dec;
    entry_t               wr_entry, head;
    logic                 unused_off;

    // Byte offset is carried by be_i, so the low address bits are dropped.
    assign unused_off = ^add_i[OffBits-1:0];

    always_comb begin
`ifdef TCDM_SHIM_SCRAMBLE_EN
        bank_dec = add_i[OffBits +: BankBits] ^ add_i[OffBits+BankBits +: BankBits];
`else
        bank_dec = add_i[OffBits +: BankBits];
`endif
        wr_entry.bank  = bank_dec;
        wr_entry.row   = add_i[AddrWidth-1 : OffBits+BankBits];
        wr_entry.wen   = wen_i;
        wr_entry.wdata = wdata_i;
        wr_entry.be    = be_i;
    end

    assign fifo_full  = (cnt_q == CntW'(FifoDepth));
    assign fifo_empty = (cnt_q == '0);
    assign outst      = OutstW'(cnt_q) + popped_q;
    assign gnt_o      = !fifo_full && (outst < OutstW'(MaxOutst));
    assign req_o      = !fifo_empty;
    assign push       = req_i && gnt_o;
    assign pop        = req_o && gnt_i;
    assign head       = mem_q[rptr_q];

    assign bank_o   = head.bank;
    assign add_o    = head.row;
    assign wen_o    = head.wen;
    assign wdata_o  = head.wdata;
    assign be_o     = head.be;
    assign outst_o  = outst;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // FIFO storage, pointers and in-flight accounting.
    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        popped_d = popped_q;
        err_d    = err_q;
        rvalid_d = rvalid_i;
        rdata_d  = rvalid_i ? rdata_i : rdata_q;

        if (push) begin
            mem_d[wptr_q] = wr_entry;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end

        // A response with nothing popped is an interconnect protocol error.
        if (pop && !rvalid_i) begin
            popped_d = popped_q + OutstW'(1);
        end else if (!pop && rvalid_i) begin
            if (popped_q == '0) begin
                err_d = 1'b1;
            end else begin
                popped_d = popped_q - OutstW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            popped_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            popped_q <= popped_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_tcdm_master_shim.sv
// Self-checking bench for tcdm_master_shim: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_tcdm_master_shim;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned MaxOutst  = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o, rvalid_o, req_o, wen_o, err_o;
    logic [31:0] rdata_o, wdata_o;
    logic [3:0]  bank_o, be_o, outst_o;
    logic [25:0] add_o;
    logic        gnt_i, rvalid_i;
    logic [31:0] rdata_i;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  bank;
        logic [25:0] row;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    // Reference model state
    txn_t        mq[$];
    int          m_popped;
    bit          m_err;
    logic [31:0] m_rdata;
    bit          m_rvalid;

    tcdm_master_shim dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .req_o(req_o), .bank_o(bank_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o),
        .be_o(be_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .outst_o(outst_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic txn_t decode(input logic [31:0] a, input logic w,
                                    input logic [31:0] d, input logic [3:0] b);
        txn_t t;
        int unsigned word;
        word = a / 4;
        t.bank = 4'(word % 16);
`ifdef TCDM_SHIM_SCRAMBLE_EN
        t.bank = t.bank ^ 4'((word / 16) % 16);
`endif
        t.row   = 26'(a / 64);
        t.wen   = w;
        t.wdata = d;
        t.be    = b;
        return t;
    endfunction

    task automatic idle_inputs();
        req_i = 0; add_i = 0; wen_i = 0; wdata_i = 0; be_i = 0;
        gnt_i = 0; rvalid_i = 0; rdata_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        @(posedge clk_i); #1;
        rst_i = 0;
        mq.delete(); m_popped = 0; m_err = 0; m_rdata = 0; m_rvalid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_o !== 1'b0 || gnt_o !== 1'b1 || outst_o !== 4'd0 || err_o !== 1'b0 ||
            rvalid_o !== 1'b0 || rdata_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_idle req=%b gnt=%b outst=%0d err=%b rvalid=%b rdata=%h want 0 1 0 0 0 0",
                     req_o, gnt_o, outst_o, err_o, rvalid_o, rdata_o);
        end
        // Queue three entries with the interconnect stalled, then reset mid-burst.
        for (int i = 0; i < 3; i++) begin
            req_i = 1; add_i = 32'h100 + 32'(i * 4); wdata_i = 32'(i);
            @(posedge clk_i); #1;
        end
        req_i = 0;
        checks++;
        if (outst_o !== 4'd3 || req_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill outst=%0d req=%b want 3 1", outst_o, req_o);
        end
        rst_i = 1;
        @(posedge clk_i); #1;
        checks++;
        if (req_o !== 1'b0 || outst_o !== 4'd0 || gnt_o !== 1'b1 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_midburst req=%b outst=%0d gnt=%b err=%b want 0 0 1 0",
                     req_o, outst_o, gnt_o, err_o);
        end
        rst_i = 0;
    endtask

    task automatic test_decode();
        logic [3:0] exp_bank;
        do_reset();
`ifdef TCDM_SHIM_SCRAMBLE_EN
        exp_bank = 4'hD;
`else
        exp_bank = 4'h9;
`endif
        req_i = 1; add_i = 32'h0000_0124; wen_i = 1; wdata_i = 32'hCAFE_0001; be_i = 4'b0110;
        @(posedge clk_i); #1;
        req_i = 0;
        checks++;
        if (req_o !== 1'b1 || bank_o !== exp_bank || add_o !== 26'h0000004 ||
            wen_o !== 1'b1 || wdata_o !== 32'hCAFE_0001 || be_o !== 4'b0110) begin
            failures++;
            $display("FAIL decode req=%b bank=%h row=%h wen=%b wdata=%h be=%b want 1 %h 0000004 1 cafe0001 0110",
                     req_o, bank_o, add_o, wen_o, wdata_o, be_o, exp_bank);
        end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        txn_t first;
        do_reset();
        first = decode(32'h200, 1'b0, 32'hA0, 4'hF);
        for (int i = 0; i < 7; i++) begin
            req_i = 1; add_i = 32'h200 + 32'(i * 68); wdata_i = 32'hA0 + 32'(i); be_i = 4'hF;
            #1;
            if (gnt_o) grants++;
            @(posedge clk_i); #1;
            checks++;
            if (bank_o !== first.bank || add_o !== first.row || wdata_o !== first.wdata || req_o !== 1'b1) begin
                failures++;
                $display("FAIL bp_head cyc=%0d bank=%h row=%h wdata=%h req=%b want %h %h %h 1",
                         i, bank_o, add_o, wdata_o, req_o, first.bank, first.row, first.wdata);
            end
        end
        req_i = 0;
        checks++;
        if (grants !== 4 || gnt_o !== 1'b0 || outst_o !== 4'd4) begin
            failures++;
            $display("FAIL bp_full grants=%0d gnt=%b outst=%0d want 4 0 4", grants, gnt_o, outst_o);
        end
    endtask

    task automatic test_outstanding();
        int grants = 0;
        do_reset();
        gnt_i = 1;
        for (int i = 0; i < 12 && grants < 10; i++) begin
            req_i = 1; add_i = 32'(i * 4);
            #1;
            if (gnt_o) grants++;
            @(posedge clk_i); #1;
        end
        req_i = 0;
        checks++;
        if (grants !== 8 || gnt_o !== 1'b0 || outst_o !== 4'd8) begin
            failures++;
            $display("FAIL outst_cap grants=%0d gnt=%b outst=%0d want 8 0 8", grants, gnt_o, outst_o);
        end
        rvalid_i = 1; rdata_i = 32'h1234_5678;
        @(posedge clk_i); #1;
        rvalid_i = 0;
        checks++;
        if (gnt_o !== 1'b1 || outst_o !== 4'd7 || rvalid_o !== 1'b1 || rdata_o !== 32'h1234_5678) begin
            failures++;
            $display("FAIL outst_release gnt=%b outst=%0d rvalid=%b rdata=%h want 1 7 1 12345678",
                     gnt_o, outst_o, rvalid_o, rdata_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            req_i = 1; add_i = 32'h40 * 32'(i);
            @(posedge clk_i); #1;
        end
        req_i = 0;
        // Fourth entry is at the head with three already popped; answer one as it pops.
        checks++;
        if (outst_o !== 4'd4 || req_o !== 1'b1) begin
            failures++;
            $display("FAIL simul_setup outst=%0d req=%b want 4 1", outst_o, req_o);
        end
        rvalid_i = 1; rdata_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        rvalid_i = 0; gnt_i = 0;
        checks++;
        if (outst_o !== 4'd3 || req_o !== 1'b0 || rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL simul outst=%0d req=%b rvalid=%b rdata=%h want 3 0 1 deadbeef",
                     outst_o, req_o, rvalid_o, rdata_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL simul_hold rvalid=%b rdata=%h want 0 deadbeef", rvalid_o, rdata_o);
        end
    endtask

    task automatic test_random();
        bit m_gnt, do_push, do_pop, rv;
        txn_t t;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_i    = ($urandom_range(0, 99) < 60);
            add_i    = $urandom;
            wen_i    = 1'($urandom);
            wdata_i  = $urandom;
            be_i     = 4'($urandom);
            gnt_i    = ($urandom_range(0, 99) < 50);
            rv       = (m_popped > 0) && ($urandom_range(0, 99) < 40);
            rvalid_i = rv;
            rdata_i  = $urandom;
            #1;
            m_gnt = (mq.size() < FifoDepth) && (mq.size() + m_popped < MaxOutst);
            checks++;
            if (gnt_o !== m_gnt || req_o !== (mq.size() > 0) || outst_o !== 4'(mq.size() + m_popped)) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d gnt=%b req=%b outst=%0d want %b %b %0d",
                         c, gnt_o, req_o, outst_o, m_gnt, mq.size() > 0, mq.size() + m_popped);
            end
            if (mq.size() > 0) begin
                checks++;
                if (bank_o !== mq[0].bank || add_o !== mq[0].row || wen_o !== mq[0].wen ||
                    wdata_o !== mq[0].wdata || be_o !== mq[0].be) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d bank=%h row=%h wen=%b wdata=%h be=%h want %h %h %b %h %h",
                             c, bank_o, add_o, wen_o, wdata_o, be_o,
                             mq[0].bank, mq[0].row, mq[0].wen, mq[0].wdata, mq[0].be);
                end
            end
            do_push = req_i && m_gnt;
            do_pop  = (mq.size() > 0) && gnt_i;
            t = decode(add_i, wen_i, wdata_i, be_i);
            @(posedge clk_i);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(t);
            if (do_pop && !rv) m_popped++;
            else if (!do_pop && rv) begin
                if (m_popped == 0) m_err = 1; else m_popped--;
            end
            m_rvalid = rv;
            if (rv) m_rdata = rdata_i;
            #1;
            checks++;
            if (rvalid_o !== m_rvalid || rdata_o !== m_rdata || err_o !== m_err) begin
                failures++;
                $display("FAIL rand_resp cyc=%0d rvalid=%b rdata=%h err=%b want %b %h %b",
                         c, rvalid_o, rdata_o, err_o, m_rvalid, m_rdata, m_err);
            end
        end
        idle_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        rvalid_i = 1; rdata_i = 32'h0BAD_F00D;
        @(posedge clk_i); #1;
        rvalid_i = 0;
        checks++;
        if (err_o !== 1'b1 || outst_o !== 4'd0 || rvalid_o !== 1'b1 || rdata_o !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL underflow err=%b outst=%0d rvalid=%b rdata=%h want 1 0 1 0badf00d",
                     err_o, outst_o, rvalid_o, rdata_o);
        end
        for (int i = 0; i < 3; i++) @(posedge clk_i);
        #1;
        checks++;
        if (err_o !== 1'b1 || outst_o !== 4'd0) begin
            failures++;
            $display("FAIL underflow_sticky err=%b outst=%0d want 1 0", err_o, outst_o);
        end
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear err=%b want 0", err_o);
        end
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        #12;
        test_reset();
        test_decode();
        test_backpressure();
        test_outstanding();
        test_simultaneous();
        test_random();
        test_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
